// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  // Counter is loaded with LAT-1 so completion lands exactly LAT edges after launch.
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               res_we;

  assign Stall = Busy | (start & ~op[2]);

  always_comb begin
    prod_s  = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    // Signed divide runs on magnitudes; MIN / -1 falls out as MIN with remainder 0.
    a_neg   = ~op_q[0] & a_q[WIDTH-1];
    b_neg   = ~op_q[0] & b_q[WIDTH-1];
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    divisor = (b_mag == '0) ? WIDTH'(1) : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;
    res_hi  = '0;
    res_lo  = '0;
    res_we  = 1'b1;
    if (!op_q[1]) begin
      res_hi = op_q[0] ? prod_u[2*WIDTH-1:WIDTH] : prod_s[2*WIDTH-1:WIDTH];
      res_lo = op_q[0] ? prod_u[WIDTH-1:0]       : prod_s[WIDTH-1:0];
    end else begin
      res_hi = rem;
      res_lo = quo;
      res_we = (b_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                op_q  <= op[1:0];
                a_q   <= A;
                b_q   <= B;
                cnt   <= op[1] ? DIV_LOAD : MULT_LOAD;
                state <= RUN;
                Busy  <= 1'b1;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == '0) begin
            if (res_we) begin
              HI <= res_hi;
              LO <= res_lo;
            end
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit against an arithmetic model
module tb_md_unit;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  md_unit #(.WIDTH(32), .MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Model: remaining busy cycles plus the pending result computed at launch.
  int          m_left = 0;
  bit          m_we   = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] p_hi   = '0;
  logic [31:0] p_lo   = '0;

  always @(posedge clk) begin
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    if (reset) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_we) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      sa = $signed(A);
      sb = $signed(B);
      ua = A;
      ub = B;
      case (op)
        3'd0: begin sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; m_we = 1; m_left = MLAT; end
        3'd1: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; m_we = 1; m_left = MLAT; end
        3'd2: begin
          m_we = (B != 0);
          if (m_we) begin sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0]; end
          m_left = DLAT;
        end
        3'd3: begin
          m_we = (B != 0);
          if (m_we) begin uq = ua / ub; ur = ua % ub; p_lo = uq[31:0]; p_hi = ur[31:0]; end
          m_left = DLAT;
        end
        3'd4: m_hi = A;
        3'd5: m_lo = A;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy",  64'(Busy),  64'(m_left > 0));
      check("model_stall", 64'(Stall), 64'((m_left > 0) || (start && op <= 3'd3)));
      check("model_hi",    64'(HI),    64'(m_hi));
      check("model_lo",    64'(LO),    64'(m_lo));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int lat);
    int n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    if (n >= 100) check({name, "_timeout"}, 64'(n), 64'(0));
    else          check({name, "_busy_len"}, 64'(n), 64'(lat));
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat);
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0;
    wait_idle(name, lat);
  endtask

  initial begin
    start = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    check("reset_busy", 64'(Busy), 64'(0));
    check("reset_hi",   64'(HI),   64'(0));
    check("reset_lo",   64'(LO),   64'(0));

    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003, MLAT);
    check("mult_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo", 64'(LO), 64'h0000_0000_FFFF_FFFA);

    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MLAT);
    check("multu_hi", 64'(HI), 64'h0000_0000_FFFF_FFFE);
    check("multu_lo", 64'(LO), 64'h0000_0000_0000_0001);

    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, DLAT);
    check("div_lo", 64'(LO), 64'h0000_0000_FFFF_FFFD);
    check("div_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);

    run_op("divu_zero", 3'd3, 32'd7, 32'd0, DLAT);
    check("divu_zero_lo", 64'(LO), 64'h0000_0000_FFFF_FFFD);
    check("divu_zero_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);

    run_op("div_min", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DLAT);
    check("div_min_lo", 64'(LO), 64'h0000_0000_8000_0000);
    check("div_min_hi", 64'(HI), 64'h0);

    run_op("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, DLAT);
    check("div_negb_lo", 64'(LO), 64'h0000_0000_FFFF_FFFD);
    check("div_negb_hi", 64'(HI), 64'd1);

    // Second start during busy cycles 2..4 with changing operands must be ignored.
    start = 1'b1; op = 3'd0; A = 32'd6; B = 32'd7;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    for (int i = 0; i < 3; i++) begin
      check("busy_stall", 64'(Stall), 64'(1));
      tick();
    end
    start = 1'b0; A = 32'h5555_5555; B = 32'hAAAA_AAAA;
    wait_idle("ignored_start", MLAT - 4);
    check("ignored_hi", 64'(HI), 64'd0);
    check("ignored_lo", 64'(LO), 64'd42);

    run_op("b2b_multu", 3'd1, 32'd3, 32'd5, MLAT);
    check("b2b_multu_lo", 64'(LO), 64'd15);
    run_op("b2b_divu", 3'd3, 32'd100, 32'd7, DLAT);
    check("b2b_divu_lo", 64'(LO), 64'd14);
    check("b2b_divu_hi", 64'(HI), 64'd2);

    start = 1'b1; op = 3'd4; A = 32'h1234_5678;
    tick();
    check("mthi_hi",   64'(HI),   64'h1234_5678);
    check("mthi_busy", 64'(Busy), 64'(0));
    op = 3'd5; A = 32'h9ABC_DEF0;
    tick();
    check("mtlo_lo",   64'(LO),   64'h9ABC_DEF0);
    check("mtlo_hi",   64'(HI),   64'h1234_5678);
    check("mtlo_busy", 64'(Busy), 64'(0));
    op = 3'd6; A = 32'hDEAD_BEEF;
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    check("nop_hi",   64'(HI),   64'h1234_5678);
    check("nop_lo",   64'(LO),   64'h9ABC_DEF0);
    check("nop_busy", 64'(Busy), 64'(0));

    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick();
    check("pre_reset_busy", 64'(Busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(Busy), 64'(0));
    check("abort_hi",   64'(HI),   64'(0));
    check("abort_lo",   64'(LO),   64'(0));
    for (int i = 0; i < DLAT + 3; i++) tick();
    check("abort_late_hi",   64'(HI),   64'(0));
    check("abort_late_lo",   64'(LO),   64'(0));
    check("abort_late_busy", 64'(Busy), 64'(0));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
